// File: rtl/od_buffer_bank.sv
// -----------------------------------------------------------------------------
// od_buffer_bank
//
// Bank of open-drain buffers for shared wired-AND lines. Each channel pulls
// its pin low when its drive request is low and the bank is enabled, and
// otherwise leaves the pin floating. Each pin is also read back. The readback
// path synchronises the pin, removes glitches and produces a clean level, a
// falling-edge strobe and a sticky stuck-low flag for the core.
//
// Parameters
//   CHANNELS      number of channels (1..16)
//   FILTER        consecutive differing samples needed to move Y_IN
//                 (0 = no filtering, Y_IN follows the synchronised pin)
//   STUCK_CYCLES  released-but-low cycles that raise FAULT (0 = monitor off)
//
// Ports
//   CLK        in     clock, all state updates on the rising edge
//   RST_N      in     asynchronous active-low reset
//   A          in     per-channel drive request, 0 pulls low (async to CLK)
//   OE         in     bank enable, 0 releases every pin (async to CLK)
//   Y          inout  open-drain pins, driven 0 or Z only
//   Y_IN       out    filtered, synchronised pin level
//   Y_FALL     out    one-cycle strobe when Y_IN goes 1->0
//   FAULT      out    sticky stuck-low flag per channel
//   CLR_FAULT  in     synchronous, level-sensitive clear for FAULT
// -----------------------------------------------------------------------------
module od_buffer_bank #(
  parameter int CHANNELS     = 6,
  parameter int FILTER       = 3,
  parameter int STUCK_CYCLES = 16
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [CHANNELS-1:0] A,
  input  logic                OE,
  inout  wire  [CHANNELS-1:0] Y,
  output logic [CHANNELS-1:0] Y_IN,
  output logic [CHANNELS-1:0] Y_FALL,
  output logic [CHANNELS-1:0] FAULT,
  input  logic                CLR_FAULT
);

  // A zero-width counter is not legal, so FILTER=0 still gets one bit of
  // width; that branch does not instantiate the counter at all.
  localparam int          FW        = (FILTER == 0) ? 1 : $clog2(FILTER + 1);
  localparam logic [15:0] STUCK_LIM = 16'(STUCK_CYCLES);

  // Drive request synchronisers. They idle high so a reset bank never pulls.
  logic [CHANNELS-1:0] r_a_s1;
  logic [CHANNELS-1:0] r_a_s2;
  logic                r_oe_s1;
  logic                r_oe_s2;

  // Registered pull-down enable, the only thing that touches the pins.
  logic [CHANNELS-1:0] r_drv;

  // Readback synchronisers, idle high to match a pulled-up bus.
  logic [CHANNELS-1:0] r_ys1;
  logic [CHANNELS-1:0] r_ys2;

  // Filtered level and its falling-edge strobe.
  logic [CHANNELS-1:0] r_y_in;
  logic [CHANNELS-1:0] r_y_fall;
  logic [CHANNELS-1:0] w_y_in_nxt;

  // ---------------------------------------------------------------------------
  // Stage p0/p1: synchronise A and OE into the clock domain
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_a_s1  <= '1;
      r_a_s2  <= '1;
      r_oe_s1 <= 1'b1;
      r_oe_s2 <= 1'b1;
    end else begin
      r_a_s1  <= A;
      r_a_s2  <= r_a_s1;
      r_oe_s1 <= OE;
      r_oe_s2 <= r_oe_s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p2: registered drive enable; the pin is a pure function of r_drv,
  // so there is no combinational path from A or OE to Y.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_drv <= '0;
    end else begin
      r_drv <= {CHANNELS{r_oe_s2}} & ~r_a_s2;
    end
  end

  // Open-drain output: low or released, never driven high.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_pin
    assign Y[gi] = r_drv[gi] ? 1'b0 : 1'bz;
  end

  // ---------------------------------------------------------------------------
  // Readback synchroniser: pin level into the clock domain
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ys1 <= '1;
      r_ys2 <= '1;
    end else begin
      r_ys1 <= Y;
      r_ys2 <= r_ys1;
    end
  end

  // ---------------------------------------------------------------------------
  // Glitch filter: next filtered level per channel
  // ---------------------------------------------------------------------------
  if (FILTER == 0) begin : g_nofilt

    always_comb begin
      w_y_in_nxt = r_ys2;
    end

  end else begin : g_filt

    logic [FW-1:0] r_fcnt     [CHANNELS];
    logic [FW-1:0] w_fcnt_nxt [CHANNELS];

    // True when this sample is the FILTER-th consecutive one that differs
    // from the current level, i.e. the count would reach FILTER now.
    function automatic logic f_filt_done(input logic [FW-1:0] cnt);
      return ((32'(cnt) + 32'd1) == 32'(FILTER));
    endfunction

    always_comb begin
      w_y_in_nxt = r_y_in;
      for (int i = 0; i < CHANNELS; i++) begin
        w_fcnt_nxt[i] = '0;
        // Any sample matching the current level restarts the count, so only
        // an unbroken run of FILTER differing samples moves the output.
        if (r_ys2[i] != r_y_in[i]) begin
          if (f_filt_done(r_fcnt[i])) begin
            w_y_in_nxt[i] = r_ys2[i];
          end else begin
            w_fcnt_nxt[i] = r_fcnt[i] + 1'b1;
          end
        end
      end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        for (int i = 0; i < CHANNELS; i++) begin
          r_fcnt[i] <= '0;
        end
      end else begin
        for (int i = 0; i < CHANNELS; i++) begin
          r_fcnt[i] <= w_fcnt_nxt[i];
        end
      end
    end

  end

  // ---------------------------------------------------------------------------
  // Filtered level register and falling-edge strobe. The strobe is taken from
  // the next level so it rises on the same edge that Y_IN falls.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_y_in   <= '1;
      r_y_fall <= '0;
    end else begin
      r_y_in   <= w_y_in_nxt;
      r_y_fall <= r_y_in & ~w_y_in_nxt;
    end
  end

  assign Y_IN   = r_y_in;
  assign Y_FALL = r_y_fall;

  // ---------------------------------------------------------------------------
  // Stuck-low monitor: counts cycles where the bank has released the line but
  // the filtered level is still low. Our own drive keeps the count at zero.
  // ---------------------------------------------------------------------------
  if (STUCK_CYCLES == 0) begin : g_nomon

    logic w_unused_clr;
    assign w_unused_clr = CLR_FAULT;
    assign FAULT        = '0;

  end else begin : g_mon

    logic [15:0]         r_sc     [CHANNELS];
    logic [15:0]         w_sc_nxt [CHANNELS];
    logic [CHANNELS-1:0] w_set;
    logic [CHANNELS-1:0] r_fault;

    // Saturating increment: the count holds at the threshold while the line
    // stays stuck, so the set condition stays asserted.
    function automatic logic [15:0] f_sat_inc(input logic [15:0] v);
      return (v >= STUCK_LIM) ? STUCK_LIM : (v + 16'd1);
    endfunction

    always_comb begin
      w_set = '0;
      for (int i = 0; i < CHANNELS; i++) begin
        w_sc_nxt[i] = (!r_drv[i] && !r_y_in[i]) ? f_sat_inc(r_sc[i]) : 16'd0;
        w_set[i]    = (w_sc_nxt[i] == STUCK_LIM);
      end
    end

    // Set has priority over clear in the same cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        for (int i = 0; i < CHANNELS; i++) begin
          r_sc[i] <= '0;
        end
        r_fault <= '0;
      end else begin
        for (int i = 0; i < CHANNELS; i++) begin
          r_sc[i] <= w_sc_nxt[i];
        end
        r_fault <= w_set | (r_fault & ~{CHANNELS{CLR_FAULT}});
      end
    end

    assign FAULT = r_fault;

  end

endmodule

// File: tb/tb_od_buffer_bank.sv
module tb_od_buffer_bank;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic [5:0] r_a;
  logic       r_oe;
  logic [5:0] r_ext;
  logic       r_clr;
  wire  [5:0] w_y;
  logic [5:0] y_in;
  logic [5:0] y_fall;
  logic [5:0] fault;

  logic [0:0] r_a1;
  logic       r_ext1;
  wire  [0:0] w_y1;
  logic [0:0] y_in1;
  logic [0:0] y_fall1;
  logic [0:0] fault1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  // Pull-ups and external open-drain devices on each line.
  for (genvar gi = 0; gi < 6; gi++) begin : g_bus
    pullup (w_y[gi]);
    assign w_y[gi] = r_ext[gi] ? 1'b0 : 1'bz;
  end
  pullup (w_y1[0]);
  assign w_y1[0] = r_ext1 ? 1'b0 : 1'bz;

  od_buffer_bank #(.CHANNELS(6), .FILTER(3), .STUCK_CYCLES(16)) dut (
    .CLK      (CLK),
    .RST_N    (rst_n),
    .A        (r_a),
    .OE       (r_oe),
    .Y        (w_y),
    .Y_IN     (y_in),
    .Y_FALL   (y_fall),
    .FAULT    (fault),
    .CLR_FAULT(r_clr)
  );

  od_buffer_bank #(.CHANNELS(1), .FILTER(0), .STUCK_CYCLES(0)) dut_c (
    .CLK      (CLK),
    .RST_N    (rst_n),
    .A        (r_a1),
    .OE       (r_oe),
    .Y        (w_y1),
    .Y_IN     (y_in1),
    .Y_FALL   (y_fall1),
    .FAULT    (fault1),
    .CLR_FAULT(r_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    rst_n  = 1'b0;
    r_a    = 6'h00;
    r_oe   = 1'b1;
    r_ext  = 6'h00;
    r_clr  = 1'b0;
    r_a1   = 1'b1;
    r_ext1 = 1'b0;

    // Reset with drive requested: everything released and idle-high.
    step(3);
    check("rst_y",     32'(w_y),    32'h3F);
    check("rst_yin",   32'(y_in),   32'h3F);
    check("rst_fall",  32'(y_fall), 32'h00);
    check("rst_fault", 32'(fault),  32'h00);
    check("rst_yin1",  32'(y_in1),  32'h1);

    // Release reset: pins low after edge 3, echo on Y_IN at edge 8.
    rst_n = 1'b1;
    step(2);
    check("drv_e2", 32'(w_y), 32'h3F);
    step(1);
    check("drv_e3", 32'(w_y), 32'h00);
    step(4);
    check("echo_e7", 32'(y_in), 32'h3F);
    step(1);
    check("echo_e8",  32'(y_in),   32'h00);
    check("fall_e8",  32'(y_fall), 32'h3F);
    step(1);
    check("fall_e9",   32'(y_fall), 32'h00);
    check("self_flt",  32'(fault),  32'h00);

    // OE gating with A=101010: only channels 0, 2, 4 pull.
    r_a = 6'b101010;
    step(2);
    check("oe_a_e2", 32'(w_y), 32'h00);
    step(1);
    check("oe_a_e3", 32'(w_y), 32'b101010);
    step(8);
    check("oe_yin", 32'(y_in), 32'b101010);
    r_oe = 1'b0;
    step(2);
    check("oe_off_e2", 32'(w_y), 32'b101010);
    step(1);
    check("oe_off_e3", 32'(w_y), 32'h3F);
    step(8);
    check("oe_off_yin",   32'(y_in),  32'h3F);
    check("oe_off_fault", 32'(fault), 32'h00);

    // Two-cycle external pulse on Y[3] is filtered out.
    r_a  = 6'h3F;
    r_oe = 1'b1;
    step(4);
    r_ext = 6'b001000;
    step(2);
    r_ext = 6'h00;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("glitch2", {20'd0, y_in, y_fall}, {20'd0, 6'h3F, 6'h00});
    end

    // Four-cycle pulse gets through with one fall strobe.
    r_ext = 6'b001000;
    step(4);
    r_ext = 6'h00;
    step(1);
    check("gl4_yin",  32'(y_in),   32'b110111);
    check("gl4_fall", 32'(y_fall), 32'b001000);
    step(1);
    check("gl4_fall_end", 32'(y_fall), 32'h00);
    step(2);
    check("gl4_yin_e8", 32'(y_in), 32'b110111);
    step(1);
    check("gl4_yin_e9", 32'(y_in),   32'h3F);
    check("gl4_rise",   32'(y_fall), 32'h00);
    check("gl4_fault",  32'(fault),  32'h00);

    // Stuck-low on channel 2: FAULT 16 cycles after Y_IN falls (edge 5 -> 21).
    step(2);
    r_ext = 6'b000100;
    step(5);
    check("stk_yin", 32'(y_in), 32'b111011);
    step(15);
    check("stk_e20", 32'(fault), 32'h00);
    step(1);
    check("stk_e21", 32'(fault), 32'b000100);
    r_ext = 6'h00;
    step(10);
    check("stk_hold", 32'(fault), 32'b000100);
    check("stk_rel",  32'(y_in),  32'h3F);

    // Clear with the line released.
    r_clr = 1'b1;
    step(1);
    r_clr = 1'b0;
    check("clr", 32'(fault), 32'h00);

    // Re-stick and clear on the setting cycle: set wins.
    r_ext = 6'b000100;
    step(20);
    check("sw_e20", 32'(fault), 32'h00);
    r_clr = 1'b1;
    step(1);
    r_clr = 1'b0;
    check("sw_e21", 32'(fault), 32'b000100);
    r_ext = 6'h00;
    step(10);
    r_clr = 1'b1;
    step(1);
    r_clr = 1'b0;
    check("sw_clr", 32'(fault), 32'h00);

    // Corner instance: no filter, no monitor, 2-cycle readback latency.
    r_ext1 = 1'b1;
    step(2);
    check("c_e2", 32'(y_in1), 32'h1);
    step(1);
    check("c_e3",   32'(y_in1),   32'h0);
    check("c_fall", 32'(y_fall1), 32'h1);
    step(1);
    check("c_fall_end", 32'(y_fall1), 32'h0);
    step(30);
    check("c_fault", 32'(fault1), 32'h0);
    r_ext1 = 1'b0;
    step(2);
    check("c_rel_e2", 32'(y_in1), 32'h0);
    step(1);
    check("c_rel_e3", 32'(y_in1), 32'h1);

    // Single-cycle pulse passes straight through when unfiltered.
    r_ext1 = 1'b1;
    step(1);
    r_ext1 = 1'b0;
    step(1);
    check("c_p_e2", 32'(y_in1), 32'h1);
    step(1);
    check("c_p_e3", 32'(y_in1), 32'h0);
    step(1);
    check("c_p_e4", 32'(y_in1), 32'h1);

    // Corner self-drive: pin low after 3 edges, echo 3 edges after that.
    r_a1 = 1'b0;
    step(3);
    check("c_drv", 32'(w_y1), 32'h0);
    step(3);
    check("c_echo",   32'(y_in1),  32'h0);
    check("c_fault2", 32'(fault1), 32'h0);
    r_a1 = 1'b1;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/od_buffer_bank.md
# od_buffer_bank

Parametrised bank of open-drain bus buffers for the CoolRunner-II designs. Each channel actively pulls its `Y` pin low when its `A` input is low and the bank is enabled, and otherwise leaves the pin high-impedance. Each pin is read back through a synchroniser and a glitch filter, which provides clean line levels and falling-edge strobes to the core. Each channel also has a stuck-low monitor that flags a pin held low by another device after this bank has released it. The block is a drop-in successor to the fixed six-channel open-drain buffer and is used wherever the CPLD shares a wired-AND line.

## Interface
Parameters:
- `CHANNELS`, default 6: number of buffer channels, range 1..16.
- `FILTER`, default 3: number of consecutive readback samples needed to change `Y_IN`. Range 0..255. 0 bypasses the filter.
- `STUCK_CYCLES`, default 16: number of released-but-low cycles that sets `FAULT`. Range 0..65535. 0 disables the monitor.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `A`  in  CHANNELS  drive request per channel: 0 pulls the pin low, 1 releases it. Asynchronous to `CLK`.
- `OE`  in  1  bank enable; 0 releases all pins. Asynchronous to `CLK`.
- `Y`  inout  CHANNELS  open-drain pins: driven 0 or Z, never driven 1.
- `Y_IN`  out  CHANNELS  filtered, synchronised pin level.
- `Y_FALL`  out  CHANNELS  one-cycle strobe when `Y_IN` goes 1→0.
- `FAULT`  out  CHANNELS  sticky stuck-low flag per channel.
- `CLR_FAULT`  in  1  synchronous clear for `FAULT`. Level-sensitive; checked every cycle.

## Operation
- Drive path:
  - `A` and `OE` each pass through a 2-flop synchroniser.
  - `drv[i] <= OE_s2 & ~A_s2[i]` (registered).
  - `Y[i]` = 0 when `drv[i]`, else Z. No combinational path from `A` to `Y`.
- Readback path: `Y` passes through a 2-flop synchroniser (`ys2`) into a per-channel filter.
  - The filter counter is `ceil(log2(FILTER+1))` bits wide.
  - If `ys2[i] == Y_IN[i]`, the counter clears.
  - Otherwise the counter increments. When it reaches `FILTER`, `Y_IN[i]` takes `ys2[i]` and the counter clears in the same cycle.
  - `FILTER=0`: `Y_IN[i] <= ys2[i]` every cycle.
- `Y_FALL[i]` is registered high for exactly the one cycle after `Y_IN[i]` goes 1→0. There is no rising strobe.
- Stuck-low monitor (per channel, 16-bit saturating counter `sc[i]`):
  - Increment while `drv[i]==0 && Y_IN[i]==0`. Clear when either condition is false. Saturate at `STUCK_CYCLES`.
  - `FAULT[i]` sets on the cycle `sc[i]` reaches `STUCK_CYCLES`.
  - `FAULT[i]` stays set until a cycle with `CLR_FAULT=1` in which the set condition is absent. If both occur in the same cycle, set wins.
  - `STUCK_CYCLES=0`: `FAULT` is held at 0.
- The bank's own drive does not produce faults: while `drv[i]=1`, `sc[i]` stays 0.
- Channels are fully independent; only `OE` and `CLR_FAULT` are shared.

## Timing
- Reset values (asynchronous, immediate on `RST_N` low):
  - `drv` = 0, so every `Y` goes Z within the same cycle.
  - All synchroniser flops = 1 (idle-high bus).
  - `Y_IN` = all 1, `Y_FALL` = 0, `FAULT` = 0, all counters = 0.
- Reset mid-operation: pins release at once and all state returns to the reset values. `FAULT` is lost.
- Drive latency: `A`/`OE` stable before rising edge k ⇒ `Y` updates after edge k+2 (3 register stages).
- Readback latency: pin change before edge k ⇒ `ys2` at edge k+1 ⇒ `Y_IN` changes at edge k+1+`FILTER` (k+2 when `FILTER=0`). `Y_FALL` rises on the same edge as `Y_IN` falls.
- Glitches: a pin pulse shorter than `FILTER` cycles (as seen at `ys2`) never reaches `Y_IN`. A return to the `Y_IN` level at any point resets the count.
- Self-drive echo: this bank's own low drive appears on `Y_IN` after 3+1+`FILTER` cycles, and is reported via `Y_FALL` like any other fall.
- Release timing: after `drv` falls, a slow-rising line counts toward `STUCK_CYCLES`. Choose `STUCK_CYCLES` to exceed the worst-case rise time plus `FILTER`+2.

## Test plan
- **Reset:** hold `RST_N`=0 with `A`=0 and `OE`=1 → all `Y`=Z, `Y_IN`=6'h3F, `FAULT`=0. Release reset → `Y[0..5]` low after 3 edges, and `Y_IN`=0 with `Y_FALL` pulsing one cycle on all channels, 4 cycles later (`FILTER`=3).
- **OE gating:** `A`=6'b101010, `OE` toggled 1→0 → `Y` = 0 on channels 0, 2, 4 while `OE`=1, all Z 3 cycles after `OE` falls. Channels 1, 3, 5 are never driven.
- **Glitch filter:** external pull-down on `Y[3]` for 2 cycles → `Y_IN[3]` stays 1 and no `Y_FALL`. Repeat for 4 cycles → `Y_IN[3]`=0 and one `Y_FALL[3]` pulse.
- **Stuck-low:** `A[2]`=1, external device holds `Y[2]` low → `FAULT[2]`=1 exactly 16 cycles after `Y_IN[2]` falls. Other `FAULT` bits stay 0. `FAULT[2]` remains set after the line is released.
- **Clear vs set:** with `FAULT[2]` set, pulse `CLR_FAULT` while `Y[2]` is released high → `FAULT[2]`=0. Then re-stick the line and assert `CLR_FAULT` on the 16th cycle → `FAULT[2]`=1 (set wins).
- **Parameter corners:** `CHANNELS`=1, `FILTER`=0, `STUCK_CYCLES`=0 → `Y_IN` follows the pin with 2-cycle latency and `FAULT` stays 0 under any stimulus.
